// File: rtl/conv_wt_bank.sv
// conv_wt_bank: double-buffered convolution weight store.
//
// Weights are loaded filter-major into the shadow bank while the active bank
// can be streamed to a MAC array, one tap of every filter per beat. A swap
// makes a completed shadow bank active. Each filter lane has its own
// synchronous-read memory holding both banks.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   load_valid/ready   load handshake for one weight word (load_data)
//   load_last          marks the final word of a full weight set
//   load_err           one-cycle pulse when load_last disagrees with the count
//   swap               request to make the shadow bank active
//   start              request to stream the active bank once
//   w_valid/w_ready    stream handshake; w_data holds tap w_tap of all lanes
//   w_last             high with the beat for tap KSIZE-1
//   busy               read FSM not idle
//   bank_rdy           active bank holds valid weights
//   shadow_full        shadow bank holds a complete set
//
// Read FSM
//   state     | meaning
//   ST_IDLE   | waiting for start with a ready bank
//   ST_FETCH  | reading tap 0 of all lanes
//   ST_STREAM | presenting a beat, advancing on w_ready

module conv_wt_bank #(
  parameter int NUM_FILT = 16,
  parameter int KSIZE    = 9,
  parameter int WT_W     = 16,
  localparam int TAP_W   = (KSIZE > 1) ? $clog2(KSIZE) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_valid,
  input  logic [WT_W-1:0]          load_data,
  input  logic                     load_last,
  output logic                     load_ready,
  output logic                     load_err,
  input  logic                     swap,
  input  logic                     start,
  input  logic                     w_ready,
  output logic                     w_valid,
  output logic [NUM_FILT*WT_W-1:0] w_data,
  output logic [TAP_W-1:0]         w_tap,
  output logic                     w_last,
  output logic                     busy,
  output logic                     bank_rdy,
  output logic                     shadow_full
);

  localparam int FILT_W = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
  localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(KSIZE - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(NUM_FILT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              bank_sel_q, bank_sel_d;
  logic              bank_rdy_q, bank_rdy_d;
  logic              shadow_full_q, shadow_full_d;
  logic              load_err_q, load_err_d;
  logic [FILT_W-1:0] filt_q, filt_d;
  logic [TAP_W-1:0]  ld_tap_q, ld_tap_d;
  logic [TAP_W-1:0]  w_tap_q, w_tap_d;

  logic             wr_en;
  logic             ld_last_word;
  logic             swap_acc;
  logic             rd_en;
  logic [TAP_W-1:0] rd_tap;

  assign wr_en        = load_valid & ~shadow_full_q;
  assign ld_last_word = (filt_q == FILT_LAST) && (ld_tap_q == TAP_LAST);
  assign swap_acc     = swap & shadow_full_q & (state_q == ST_IDLE);

  // Load side: separate filter/tap counters walk the shadow bank filter-major.
  always_comb begin
    filt_d        = filt_q;
    ld_tap_d      = ld_tap_q;
    shadow_full_d = shadow_full_q;
    load_err_d    = 1'b0;
    if (wr_en) begin
      load_err_d = load_last ^ ld_last_word;
      if (ld_last_word) begin
        filt_d        = '0;
        ld_tap_d      = '0;
        shadow_full_d = 1'b1;
      end else if (ld_tap_q == TAP_LAST) begin
        ld_tap_d = '0;
        filt_d   = filt_q + 1'b1;
      end else begin
        ld_tap_d = ld_tap_q + 1'b1;
      end
    end
    // A swap needs shadow_full already set, so it never meets a write.
    if (swap_acc) shadow_full_d = 1'b0;
  end

  assign bank_sel_d = bank_sel_q ^ swap_acc;
  assign bank_rdy_d = bank_rdy_q | swap_acc;

  // Read FSM: the memory read for the next tap is issued on the same edge
  // that accepts the current beat, so beats flow back to back.
  always_comb begin
    state_d = state_q;
    w_tap_d = w_tap_q;
    rd_en   = 1'b0;
    rd_tap  = w_tap_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start && bank_rdy_q && !swap_acc) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        rd_en   = 1'b1;
        rd_tap  = '0;
        w_tap_d = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_ready) begin
          if (w_tap_q == TAP_LAST) begin
            state_d = ST_IDLE;
            w_tap_d = '0;
          end else begin
            rd_en   = 1'b1;
            w_tap_d = w_tap_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      bank_sel_q    <= 1'b0;
      bank_rdy_q    <= 1'b0;
      shadow_full_q <= 1'b0;
      load_err_q    <= 1'b0;
      filt_q        <= '0;
      ld_tap_q      <= '0;
      w_tap_q       <= '0;
    end else begin
      state_q       <= state_d;
      bank_sel_q    <= bank_sel_d;
      bank_rdy_q    <= bank_rdy_d;
      shadow_full_q <= shadow_full_d;
      load_err_q    <= load_err_d;
      filt_q        <= filt_d;
      ld_tap_q      <= ld_tap_d;
      w_tap_q       <= w_tap_d;
    end
  end

  // One memory per filter lane; bank index is the top address bit.
  // Writes go to the shadow bank, reads come from the active bank.
  for (genvar f = 0; f < NUM_FILT; f++) begin : g_lane
    logic [WT_W-1:0] mem_q [2][KSIZE];
    logic [WT_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (wr_en && (filt_q == FILT_W'(f))) mem_q[~bank_sel_q][ld_tap_q] <= load_data;
    end

    // Read register is reset so w_data comes up as zero; the array is not.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_q <= '0;
      else if (rd_en) rd_q <= mem_q[bank_sel_q][rd_tap];
    end

    assign w_data[f*WT_W +: WT_W] = rd_q;
  end

  assign load_ready  = ~shadow_full_q;
  assign load_err    = load_err_q;
  assign w_valid     = (state_q == ST_STREAM);
  assign w_tap       = w_tap_q;
  assign w_last      = (state_q == ST_STREAM) && (w_tap_q == TAP_LAST);
  assign busy        = (state_q != ST_IDLE);
  assign bank_rdy    = bank_rdy_q;
  assign shadow_full = shadow_full_q;

endmodule

// File: doc/conv_wt_bank.md
CONV_WT_BANK -- requirements
Module: conv_wt_bank

Interface
REQ-001 SHALL have parameter NUM_FILT, default 16, number of filters (one MAC lane per filter).
REQ-002 SHALL have parameter KSIZE, default 9, weights (taps) per filter.
REQ-003 SHALL have parameter WT_W, default 16, bits per weight; TAP_W = max(1, clog2(KSIZE)).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port load_valid  input  1  load word present.
REQ-007 SHALL have port load_data  input  WT_W  weight being loaded.
REQ-008 SHALL have port load_last  input  1  marks final word of a full weight set.
REQ-009 SHALL have port load_ready  output  1  shadow bank accepts a word.
REQ-010 SHALL have port load_err  output  1  one-cycle pulse on load_last mismatch.
REQ-011 SHALL have port swap  input  1  request to make the shadow bank active.
REQ-012 SHALL have port start  input  1  request to stream the active bank once.
REQ-013 SHALL have port w_ready  input  1  consumer accepts a beat.
REQ-014 SHALL have port w_valid  output  1  beat present.
REQ-015 SHALL have port w_data  output  NUM_FILT*WT_W  tap t of every filter; filter f in bits [f*WT_W +: WT_W].
REQ-016 SHALL have port w_tap  output  TAP_W  tap index of current beat.
REQ-017 SHALL have port w_last  output  1  high with beat for tap KSIZE-1.
REQ-018 SHALL have port busy  output  1  read FSM not IDLE.
REQ-019 SHALL have ports bank_rdy and shadow_full  output  1 each  active bank holds valid weights / shadow bank complete.

Function
REQ-020 SHALL hold two banks (active, shadow), each NUM_FILT lanes x KSIZE words; each lane is its own synchronous-read memory.
REQ-021 Load order SHALL be filter-major: word n goes to filter n/KSIZE, tap n%KSIZE of the shadow bank, tracked by separate filter/tap counters (no divider).
REQ-022 load_ready SHALL equal !shadow_full; a word is written on load_valid & load_ready.
REQ-023 On the write of word NUM_FILT*KSIZE-1: shadow_full SHALL set and counters SHALL return to 0.
REQ-024 load_err SHALL pulse the cycle after a write where load_last differs from (word index == NUM_FILT*KSIZE-1); the word is still written and counting is unaffected.
REQ-025 swap SHALL be accepted only when shadow_full=1 and read FSM is IDLE; on acceptance the bank select toggles, bank_rdy sets, shadow_full clears; otherwise swap is ignored with no state change.
REQ-026 Read FSM states: IDLE, FETCH, STREAM.
REQ-027 IDLE->FETCH when start=1, bank_rdy=1 and no swap accepted in the same cycle; start is otherwise ignored (swap has priority).
REQ-028 FETCH SHALL read tap 0 of all lanes and go to STREAM; w_valid first rises 2 cycles after the cycle start is sampled high.
REQ-029 In STREAM w_valid SHALL be 1; w_data/w_tap/w_last SHALL hold stable while w_valid & !w_ready.
REQ-030 On w_valid & w_ready with w_last=0: read next tap at the same edge; w_tap increments; w_valid stays 1 (one beat per cycle under continuous w_ready).
REQ-031 On w_valid & w_ready with w_last=1: go to IDLE, w_valid and busy low next cycle; bank_rdy unchanged (bank reusable).
REQ-032 start during FETCH/STREAM SHALL be ignored.
REQ-033 Loading the shadow bank SHALL proceed concurrently with streaming the active bank without interference.

Reset
REQ-034 On rst_n=0: FSM to IDLE, bank select 0, counters 0, bank_rdy=0, shadow_full=0, load_ready=1, load_err=0, w_valid=0, w_last=0, w_tap=0, busy=0, w_data=0.
REQ-035 Memory contents SHALL NOT be reset; reset mid-load discards the partial set, reset mid-stream drops the burst.

Verification (NUM_FILT=16, KSIZE=9, WT_W=16)
REQ-036 Load 144 words value 16'h0100+n, load_last on n=143 -> shadow_full=1, load_ready=0, load_err never pulses.
REQ-037 swap, then start with w_ready=1 -> w_valid 2 cycles later, 9 consecutive beats, beat t lane f = 16'h0100+9f+t, w_last on t=8, busy low after.
REQ-038 Stream with w_ready toggling 1/0 -> w_data/w_tap stable while stalled, exactly 9 beats, none repeated or skipped.
REQ-039 load_last on word 10 -> load_err pulses one cycle; loading continues and completes at word 143.
REQ-040 swap during STREAM, or start with bank_rdy=0, or swap+start same cycle -> request ignored/swap wins per REQ-025/027; check bank_rdy, busy.
REQ-041 Assert rst_n low at beat 4 and mid-load at word 50 -> all outputs at REQ-034 values; new load then starts at filter 0 tap 0.
